// File: rtl/dm_arbiter.sv
// Data-memory sequencer shared between the pipeline MEM stage and an external
// loader/debug port; fixed-latency access with starvation-bounded arbitration.
module dm_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            owner_ext;
    logic [CW-1:0]   cnt;
    logic [SCW-1:0]  starve_cnt;
    logic            cpu_req;
    logic            grant_cpu;
    logic            grant_ext;
    logic            last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cpu_req   = cpu_re | cpu_we;
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        last_beat = (state == ACCESS) && (32'(cnt) == MEM_LAT - 1);
        case (state)
            IDLE: begin
                if (ext_req && (!cpu_req || 32'(starve_cnt) >= STARVE_MAX)) begin
                    grant_ext = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end
                if (grant_ext || grant_cpu) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (last_beat) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // The DONE cycle releases the CPU even though its request is still up.
        cpu_stall = !rst && cpu_req && !(state == DONE && !owner_ext);
        ext_gnt   = !rst && grant_ext;
        ext_done  = !rst && (state == DONE) && owner_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ext  <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
        end else if (grant_ext || grant_cpu) begin
            owner_ext <= grant_ext;
            cnt       <= '0;
            mem_addr  <= grant_ext ? ext_addr : cpu_addr;
            mem_din   <= grant_ext ? ext_wdata : cpu_wdata;
            mem_we    <= grant_ext ? ext_we : cpu_we;
            mem_re    <= grant_ext ? !ext_we : !cpu_we;
            if (grant_ext || !ext_req) begin
                starve_cnt <= '0;
            end else if (32'(starve_cnt) < STARVE_MAX) begin
                starve_cnt <= starve_cnt + SCW'(1);
            end
        end else if (state == ACCESS) begin
            cnt <= cnt + CW'(1);
            if (last_beat) begin
                mem_re <= 1'b0;
                mem_we <= 1'b0;
                if (mem_re) begin
                    if (owner_ext) begin
                        ext_rdata <= mem_dout;
                    end else begin
                        cpu_rdata <= mem_dout;
                    end
                end
            end
        end
    end

endmodule
